mult_seq: RTL and testbench

- Multi-cycle signed 8x8 shift-add multiply sequencer for the picoMIPS multiply instruction.
- Accepts operands from the register RAM read ports and stalls the program counter while it iterates.
- Writes the Q1.7 fractional (or integer low-byte) product back through the RAM write path with a one-cycle active-low write strobe.
- Sits between the decoder (start), the RAM (operands, nw, Wdata) and the program_counter (stall).

---
 rtl/mult_seq_pkg.sv | 18 +
 rtl/mult_seq_if.sv | 16 +
 rtl/mult_seq_datapath.sv | 61 ++++++
 rtl/mult_seq.sv | 106 ++++++++++
 tb/tb_mult_seq.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the picoMIPS multiply sequencer.
package pico_mult_pkg;

  localparam int MULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Two's-complement negate when neg is set; callers zero-extend into and
  // slice out of the 32-bit container, which keeps the helper width-agnostic.
  function automatic logic [31:0] neg_cond(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Decoder/RAM-facing handshake of the multiply sequencer.
import pico_mult_pkg::*;

interface mult_seq_if #(parameter int WIDTH = MULT_WIDTH);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             busy;
  logic             done;
  logic             nw;
  logic [WIDTH-1:0] result;

  modport master (output start, a, b, input stall, busy, done, nw, result);
  modport slave  (input start, a, b, output stall, busy, done, nw, result);
endinterface

// File: rtl/mult_seq_datapath.sv
// Operand magnitude capture, shift-add accumulator and iteration down-counter.
import pico_mult_pkg::*;

module mult_datapath #(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk_sys,
  input  logic               rst_b,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic               sign,
  output logic               last
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        a_w;
  logic [31:0]        b_w;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               unused_bits;

  // Magnitude of the most negative value is kept as the unsigned 2^(WIDTH-1).
  assign a_w   = neg_cond(a[WIDTH-1], {{(32-WIDTH){1'b0}}, a});
  assign b_w   = neg_cond(b[WIDTH-1], {{(32-WIDTH){1'b0}}, b});
  assign a_mag = a_w[WIDTH-1:0];
  assign b_mag = b_w[WIDTH-1:0];
  assign unused_bits = ^{a_w[31:WIDTH], b_w[31:WIDTH]};

  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;
  assign last    = (cnt == '0);

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
      cnt    <= CNT_W'(WIDTH-1);
      sign   <= a[WIDTH-1] ^ b[WIDTH-1];
    end else if (step) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mult_seq.sv
// Multi-cycle signed multiply sequencer: FSM, stall/strobe decode, result format.
// Build option: MULT_SEQ_SAT_EN saturates out-of-range Q1.7 results.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | WIDTH shift-add iterations, PC stalled
// DONE  | result valid, done pulse and nw write strobe low
import pico_mult_pkg::*;

module mult_seq #(
  parameter int WIDTH = MULT_WIDTH,
  parameter int FRAC  = 1
) (
  input  logic     Clock,
  input  logic     nReset,
  mult_seq_if.slave bus
);

  mult_state_t state, state_nxt;

  logic               load;
  logic               step;
  logic               sign;
  logic               last;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [31:0]        prod_w;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   result_fmt;
  logic [WIDTH-1:0]   result_q;
  logic               unused_bits;

  mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk_sys (Clock),
    .rst_b   (nReset),
    .load    (load),
    .step    (step),
    .a       (bus.a),
    .b       (bus.b),
    .acc_nxt (acc_nxt),
    .sign    (sign),
    .last    (last)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The result is formatted from the final iteration's sum so it is already
  // registered and valid while done/nw are asserted.
  assign prod_w = neg_cond(sign, {{(32-2*WIDTH){1'b0}}, acc_nxt});
  assign prod   = prod_w[2*WIDTH-1:0];
  assign unused_bits = ^{prod_w[31:2*WIDTH], prod[2*WIDTH-1]};

  always_comb begin
    result_fmt = prod[WIDTH-1:0];
    if (FRAC != 0) begin
      result_fmt = prod[2*WIDTH-2:WIDTH-1];
`ifdef MULT_SEQ_SAT_EN
      if (prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod[2*WIDTH-1]}}) begin
        result_fmt = prod[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
      end
`else
`endif
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      result_q <= '0;
    end else if (state == RUN && last) begin
      result_q <= result_fmt;
    end
  end

  assign bus.stall  = (state == IDLE && bus.start) || (state == RUN);
  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.nw     = (state != DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_mult_seq.sv
// Randomised self-checking bench for mult_seq, FRAC=1 and FRAC=0 instances in lockstep.
module tb_mult_seq;
  import pico_mult_pkg::*;

  logic Clock = 1'b0;
  logic nReset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  mult_seq_if #(.WIDTH(8)) if_q ();
  mult_seq_if #(.WIDTH(8)) if_i ();

  mult_seq #(.WIDTH(8), .FRAC(1)) dut_q (.Clock(Clock), .nReset(nReset), .bus(if_q));
  mult_seq #(.WIDTH(8), .FRAC(0)) dut_i (.Clock(Clock), .nReset(nReset), .bus(if_i));

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed integer product, then floor shift / low byte.
  function automatic logic [7:0] model(input logic [7:0] av, input logic [7:0] bv, input bit frac);
    int p;
    int sa;
    int sb;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    p  = sa * sb;
    if (frac) begin
      p = p >>> 7;
`ifdef MULT_SEQ_SAT_EN
      if (p > 127)  p = 127;
      if (p < -128) p = -128;
`endif
    end
    return p[7:0];
  endfunction

  task automatic drive(input logic st, input logic [7:0] av, input logic [7:0] bv);
    if_q.start = st; if_q.a = av; if_q.b = bv;
    if_i.start = st; if_i.a = av; if_i.b = bv;
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] exp_q, input logic [7:0] exp_i);
    check({tag, "_nw"},    {30'd0, if_q.nw, if_i.nw},       32'd3);
    check({tag, "_done"},  {30'd0, if_q.done, if_i.done},   32'd0);
    check({tag, "_busy"},  {30'd0, if_q.busy, if_i.busy},   32'd0);
    check({tag, "_stall"}, {30'd0, if_q.stall, if_i.stall}, 32'd0);
    check({tag, "_res"},   {16'd0, if_q.result, if_i.result}, {16'd0, exp_q, exp_i});
  endtask

  // One multiply; scramble toggles start/operands during RUN, chain leaves
  // start high so the next call begins in the IDLE cycle after DONE.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input bit scramble, input bit chain);
    int stall_cycles;
    int busy_cycles;
    int done_at;
    logic [7:0] exp_q;
    logic [7:0] exp_i;
    exp_q = model(av, bv, 1'b1);
    exp_i = model(av, bv, 1'b0);
    stall_cycles = 0;
    busy_cycles  = 0;
    done_at      = -1;
    @(negedge Clock);
    drive(1'b1, av, bv);
    #1;
    check("stall_on_start", {31'd0, if_q.stall}, 32'd1);
    stall_cycles++;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clock);
      if (if_q.done || if_i.done) begin
        done_at = k;
        break;
      end
      if (if_q.stall) stall_cycles++;
      if (if_q.busy && if_i.busy) busy_cycles++;
      if (scramble) drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      else          drive(1'b0, 8'($urandom), 8'($urandom));
    end
    check("latency", done_at, 9);
    check("stall_cycles", stall_cycles, 9);
    check("busy_cycles", busy_cycles, 8);
    check("done_both", {30'd0, if_q.done, if_i.done}, 32'd3);
    check("nw_low", {30'd0, if_q.nw, if_i.nw}, 32'd0);
    check("stall_in_done", {31'd0, if_q.stall}, 32'd0);
    check("res_frac1", {24'd0, if_q.result}, {24'd0, exp_q});
    check("res_frac0", {24'd0, if_i.result}, {24'd0, exp_i});
    if (chain) begin
      drive(1'b1, 8'($urandom), 8'($urandom));
    end else begin
      drive(1'b0, 8'($urandom), 8'($urandom));
      @(negedge Clock);
      check_idle_outputs("post_done", exp_q, exp_i);
    end
  endtask

  task automatic abort_op(input logic [7:0] av, input logic [7:0] bv);
    bit saw_write;
    saw_write = 1'b0;
    @(negedge Clock);
    drive(1'b1, av, bv);
    for (int k = 1; k <= 4; k++) begin
      @(negedge Clock);
      drive(1'b0, av, bv);
    end
    check("abort_busy_before", {31'd0, if_q.busy}, 32'd1);
    nReset = 1'b0;
    #1;
    check_idle_outputs("abort", 8'h00, 8'h00);
    for (int k = 0; k < 12; k++) begin
      @(negedge Clock);
      if (if_q.done || !if_q.nw || if_i.done || !if_i.nw) saw_write = 1'b1;
      if (k == 3) nReset = 1'b1;
    end
    check("abort_no_write", {31'd0, saw_write}, 32'd0);
  endtask

  initial begin
    drive(1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge Clock);
    check_idle_outputs("reset", 8'h00, 8'h00);
    nReset = 1'b1;
    @(negedge Clock);
    check_idle_outputs("idle", 8'h00, 8'h00);

    run_op(8'h40, 8'h40, 1'b0, 1'b0);
    run_op(8'hC0, 8'h40, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 1'b0);
    run_op(8'h0D, 8'h0B, 1'b1, 1'b0);
    run_op(8'hFD, 8'h05, 1'b1, 1'b0);
    run_op(8'h7F, 8'h80, 1'b0, 1'b1);
    run_op(8'h80, 8'h7F, 1'b1, 1'b1);
    run_op(8'h00, 8'h9C, 1'b0, 1'b0);

    abort_op(8'h55, 8'hAA);
    run_op(8'h23, 8'hE7, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drive(1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge Clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
